usb_cmd_frame_parser: RTL

Byte-stream command deframer between the USB receive path and the command handlers (I2C config/write/read, etc.) inside `cdc`. It consumes raw `usb_data_in`/`usb_data_valid_in` bytes and locates frames of the form `AA 55 CMD LEN_H LEN_L PAYLOAD[LEN] CKSUM`. It publishes the command type and length, then streams the payload bytes with an index. Each frame ends with a done or error pulse, so handlers can commit the command or discard it.

---
 rtl/usb_cmd_frame_parser.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/usb_cmd_frame_parser.sv
// Deframes the USB receive byte stream (AA 55 CMD LEN_H LEN_L PAYLOAD CKSUM) into
// command header, indexed payload bytes and a done/error pulse per frame.
module usb_cmd_frame_parser #(
    parameter int MAX_PAYLOAD_LEN = 256,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  usb_data_in,
    input  logic        usb_data_valid_in,
    output logic [7:0]  cmd_type,
    output logic [15:0] cmd_length,
    output logic        cmd_start,
    output logic [7:0]  cmd_data,
    output logic [15:0] cmd_data_index,
    output logic        cmd_data_valid,
    output logic        cmd_done,
    output logic        parse_error,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYCLES);
    localparam logic [16:0]   MAX_LEN     = 17'(MAX_PAYLOAD_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC2,
        ST_CMD,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CKSUM
    } state_t;

    state_t          state;
    logic [7:0]      sum;
    logic [7:0]      cmd_latch;
    logic [7:0]      len_h;
    logic [15:0]     byte_count;
    logic [TW-1:0]   timeout_cnt;
    logic [15:0]     frame_len;
    logic            timed_out;

    assign frame_len = {len_h, usb_data_in};
    assign timed_out = (state != ST_IDLE) && !usb_data_valid_in && (timeout_cnt == TIMEOUT_LIM);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            sum            <= 8'h00;
            cmd_latch      <= 8'h00;
            len_h          <= 8'h00;
            byte_count     <= 16'h0000;
            timeout_cnt    <= '0;
            cmd_type       <= 8'h00;
            cmd_length     <= 16'h0000;
            cmd_start      <= 1'b0;
            cmd_data       <= 8'h00;
            cmd_data_index <= 16'h0000;
            cmd_data_valid <= 1'b0;
            cmd_done       <= 1'b0;
            parse_error    <= 1'b0;
            err_code       <= 2'd0;
        end else begin
            cmd_start      <= 1'b0;
            cmd_data_valid <= 1'b0;
            cmd_done       <= 1'b0;
            parse_error    <= 1'b0;

            // Idle-clock counter saturates at the limit; any byte restarts it
            if (state == ST_IDLE || usb_data_valid_in)
                timeout_cnt <= '0;
            else if (timeout_cnt != TIMEOUT_LIM)
                timeout_cnt <= timeout_cnt + 1'b1;

            if (timed_out) begin
                parse_error <= 1'b1;
                err_code    <= 2'd3;
                state       <= ST_IDLE;
            end else if (usb_data_valid_in) begin
                case (state)
                    ST_IDLE: begin
                        if (usb_data_in == 8'hAA)
                            state <= ST_SYNC2;
                    end
                    ST_SYNC2: begin
                        if (usb_data_in == 8'h55)
                            state <= ST_CMD;
                        else if (usb_data_in != 8'hAA)
                            state <= ST_IDLE;
                    end
                    ST_CMD: begin
                        cmd_latch <= usb_data_in;
                        sum       <= usb_data_in;
                        state     <= ST_LEN_H;
                    end
                    ST_LEN_H: begin
                        len_h <= usb_data_in;
                        sum   <= sum + usb_data_in;
                        state <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        sum <= sum + usb_data_in;
                        if ({1'b0, frame_len} > MAX_LEN) begin
                            parse_error <= 1'b1;
                            err_code    <= 2'd2;
                            state       <= ST_IDLE;
                        end else begin
                            cmd_start  <= 1'b1;
                            cmd_type   <= cmd_latch;
                            cmd_length <= frame_len;
                            err_code   <= 2'd0;
                            byte_count <= 16'h0000;
                            state      <= (frame_len == 16'h0000) ? ST_CKSUM : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        cmd_data       <= usb_data_in;
                        cmd_data_index <= byte_count;
                        cmd_data_valid <= 1'b1;
                        sum            <= sum + usb_data_in;
                        byte_count     <= byte_count + 16'd1;
                        if (byte_count == cmd_length - 16'd1)
                            state <= ST_CKSUM;
                    end
                    ST_CKSUM: begin
                        if (usb_data_in == sum) begin
                            cmd_done <= 1'b1;
                        end else begin
                            parse_error <= 1'b1;
                            err_code    <= 2'd1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
